// File: rtl/aes_pkg.sv
// aes_pkg: shared AES widths, round counts and round-index type
package aes_pkg;
  localparam int AES_BLOCK_W = 128;
  localparam int NR_128 = 10;
  localparam int NR_192 = 12;
  localparam int NR_256 = 14;
  typedef logic [3:0] round_idx_t;
endpackage

// File: rtl/round_key_bank.sv
// round_key_bank: NR+1 round-key registers, range-checked write port, async read port
module round_key_bank import aes_pkg::*; #(
  parameter int NR = NR_128,
  parameter int BLOCK_W = AES_BLOCK_W,
  parameter int IDX_W = $bits(round_idx_t)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [IDX_W-1:0]   wr_idx,
  input  logic [BLOCK_W-1:0] wr_data,
  input  logic [IDX_W-1:0]   rd_idx,
  output logic [BLOCK_W-1:0] rd_data,
  output logic               err
);
  logic [BLOCK_W-1:0] keys [NR+1];
  assign rd_data = keys[rd_idx];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int i = 0; i <= NR; i++) keys[i] <= '0;
      err <= 1'b0;
    end else if (wr_en) begin
      if (wr_idx <= IDX_W'(NR)) keys[wr_idx] <= wr_data;
      else err <= 1'b1;
    end
endmodule

// File: rtl/inv_add_round_key_seq.sv
// inv_add_round_key_seq: streams decryption states through XOR with round keys NR..0
module inv_add_round_key_seq import aes_pkg::*; #(
  parameter int NR = NR_128,
  parameter int BLOCK_W = AES_BLOCK_W,
  parameter int IDX_W = $bits(round_idx_t)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               key_wr_en,
  input  logic [IDX_W-1:0]   key_wr_idx,
  input  logic [BLOCK_W-1:0] key_wr_data,
  input  logic               start,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [BLOCK_W-1:0] in_state,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BLOCK_W-1:0] out_state,
  output logic [IDX_W-1:0]   out_round,
  output logic               out_last,
  output logic               err
);
  logic [IDX_W-1:0] rptr, rsel;
  logic [BLOCK_W-1:0] key;
  logic acc;
  assign in_ready = !out_valid || out_ready;
  assign acc = in_valid && in_ready;
  // start overrides the pointer combinationally so a coincident beat uses key[NR]
  assign rsel = start ? IDX_W'(NR) : rptr;
  round_key_bank #(.NR(NR), .BLOCK_W(BLOCK_W), .IDX_W(IDX_W)) bank (
    .clk(clk), .rst(rst), .wr_en(key_wr_en), .wr_idx(key_wr_idx),
    .wr_data(key_wr_data), .rd_idx(rsel), .rd_data(key), .err(err)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rptr <= IDX_W'(NR);
      out_valid <= 1'b0;
      out_state <= '0;
      out_round <= '0;
      out_last <= 1'b0;
    end else begin
      if (acc) begin
        out_state <= in_state ^ key;
        out_round <= rsel;
        out_last <= rsel == '0;
        rptr <= rsel == '0 ? IDX_W'(NR) : rsel - 1'b1;
      end else if (start) rptr <= IDX_W'(NR);
      if (acc) out_valid <= 1'b1;
      else if (out_ready) out_valid <= 1'b0;
    end
endmodule

// File: tb/tb_inv_add_round_key_seq.sv
// tb_inv_add_round_key_seq: directed vectors checked against a behavioural key-schedule model
module tb_inv_add_round_key_seq;
  localparam int NR = 10;
  logic clk = 0, rst = 1;
  logic key_wr_en = 0, start = 0, in_valid = 0, out_ready = 0;
  logic [3:0] key_wr_idx = 0;
  logic [127:0] key_wr_data = 0, in_state = 0;
  logic in_ready, out_valid, out_last, err;
  logic [127:0] out_state, held;
  logic [3:0] out_round;
  int nchk = 0, nerr = 0;
  logic [127:0] mk [0:NR];
  int mr, er;
  logic ev, el, ee;
  logic [127:0] es;

  inv_add_round_key_seq dut (
    .clk(clk), .rst(rst), .key_wr_en(key_wr_en), .key_wr_idx(key_wr_idx),
    .key_wr_data(key_wr_data), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_state(in_state), .out_valid(out_valid), .out_ready(out_ready), .out_state(out_state),
    .out_round(out_round), .out_last(out_last), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [127:0] a, input logic [127:0] e);
    nchk++;
    if (a !== e) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // model: the next beat takes key[round] where round counts down from NR, restarting on start or after 0
  always @(posedge clk or posedge rst)
    if (rst) begin
      for (int i = 0; i <= NR; i++) mk[i] <= '0;
      mr <= NR; ev <= 0; es <= '0; er <= 0; el <= 0; ee <= 0;
    end else begin : model
      automatic bit acc = in_valid && (!ev || out_ready);
      automatic int r = start ? NR : mr;
      if (key_wr_en) begin
        if (int'(key_wr_idx) <= NR) mk[key_wr_idx] <= key_wr_data;
        else ee <= 1;
      end
      if (acc) begin
        es <= in_state ^ mk[r];
        er <= r;
        el <= r == 0;
        mr <= r == 0 ? NR : r - 1;
        ev <= 1;
      end else begin
        if (start) mr <= NR;
        if (out_ready) ev <= 0;
      end
    end

  always @(negedge clk)
    if (!rst) begin
      chk("out_valid", 128'(out_valid), 128'(ev));
      chk("in_ready", 128'(in_ready), 128'(!ev || out_ready));
      chk("err", 128'(err), 128'(ee));
      if (ev) begin
        chk("out_state", out_state, es);
        chk("out_round", 128'(out_round), 128'(er));
        chk("out_last", 128'(out_last), 128'(el));
      end
    end

  initial begin
    tick();
    rst = 0;
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_in_ready", 128'(in_ready), 128'(1));
    chk("rst_out_state", out_state, 128'(0));
    chk("rst_err", 128'(err), 128'(0));
    // known vector
    key_wr_en = 1; key_wr_idx = 10; key_wr_data = 128'hD4BF5D30E0B452AEB84111F11E2798E5;
    tick();
    key_wr_en = 0; start = 1; in_valid = 1; out_ready = 1;
    in_state = 128'h046681E5E0CB199A48F8D37A2806264C;
    tick();
    chk("kv_state", out_state, 128'hd0d9dcd5007f4b34f0b9c28b3621bea9);
    chk("kv_round", 128'(out_round), 128'(10));
    chk("kv_last", 128'(out_last), 128'(0));
    start = 0; in_valid = 0;
    tick();
    // full block with wrap
    for (int i = 0; i <= NR; i++) begin
      key_wr_en = 1; key_wr_idx = 4'(i); key_wr_data = {16{8'(i)}};
      tick();
    end
    key_wr_en = 0;
    for (int k = 0; k < 12; k++) begin
      start = k == 0; in_valid = 1; in_state = '0;
      tick();
      chk("blk_state", out_state, {16{8'(k < 11 ? 10 - k : 10)}});
      chk("blk_last", 128'(out_last), 128'(k == 10));
    end
    start = 0; in_valid = 0;
    tick();
    // backpressure, pointer now at 9
    out_ready = 0; in_valid = 1; in_state = {8{16'h1111}};
    tick();
    held = out_state;
    chk("bp_in_ready", 128'(in_ready), 128'(0));
    for (int k = 0; k < 3; k++) begin
      in_state = {4{32'(k + 7)}};
      tick();
      chk("bp_hold_state", out_state, held);
      chk("bp_hold_round", 128'(out_round), 128'(9));
    end
    out_ready = 1;
    tick();
    chk("bp_next_round", 128'(out_round), 128'(8));
    in_valid = 0;
    tick();
    // start mid-block
    start = 1;
    tick();
    start = 0;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1; in_state = {4{32'(k * 32'h01234567)}};
      tick();
    end
    start = 1;
    tick();
    chk("mid_start_round", 128'(out_round), 128'(10));
    start = 0;
    tick();
    chk("after_start_round", 128'(out_round), 128'(9));
    in_valid = 0;
    tick();
    // bad index and same-cycle write/read hazard
    key_wr_en = 1; key_wr_idx = 11; key_wr_data = '1;
    tick();
    chk("err_set", 128'(err), 128'(1));
    key_wr_idx = 10; key_wr_data = '1; start = 1; in_valid = 1; in_state = '0;
    tick();
    chk("hazard_old_key", out_state, {16{8'h0a}});
    key_wr_en = 0;
    tick();
    chk("hazard_new_key", out_state, '1);
    start = 0;
    tick();
    // async reset between edges
    @(posedge clk);
    #2 rst = 1;
    #1;
    chk("arst_out_valid", 128'(out_valid), 128'(0));
    chk("arst_err", 128'(err), 128'(0));
    @(negedge clk);
    #1 rst = 0; in_state = 128'hdeadbeef_01020304_a5a5a5a5_0f0f0f0f;
    tick();
    chk("post_rst_state", out_state, 128'hdeadbeef_01020304_a5a5a5a5_0f0f0f0f);
    chk("post_rst_round", 128'(out_round), 128'(10));
    in_valid = 0;
    tick();
    tick();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule

// File: doc/inv_add_round_key_seq.md
Name: inv_add_round_key_seq

Overview:
Sequential, parametrised successor to the combinational inverse AddRoundKey XOR. It holds a bank of NR+1 round keys and applies them to a stream of decryption states in descending round order (NR down to 0). Each application is one valid/ready beat with a registered output. It sits between the inverse-round datapath and the key expansion logic, so the decryption core no longer routes a separate key to each round.

Parameters:
NR, 10, number of cipher rounds; legal values 10, 12, 14 (AES-128/192/256); key bank depth is NR+1
BLOCK_W, 128, state and round-key width in bits
IDX_W, 4, width of round index fields; must satisfy 2^IDX_W > NR

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
key_wr_en  input  1  write key_wr_data into key bank entry key_wr_idx
key_wr_idx  input  IDX_W  key bank write index, 0..NR
key_wr_data  input  BLOCK_W  round key value
start  input  1  single-cycle pulse; reloads round pointer to NR (new block)
in_valid  input  1  in_state valid
in_ready  output  1  block can accept in_state this cycle
in_state  input  BLOCK_W  state entering AddRoundKey
out_valid  output  1  out_state valid
out_ready  input  1  downstream accepts out_state
out_state  output  BLOCK_W  in_state XOR key[round]
out_round  output  IDX_W  round index whose key produced out_state
out_last  output  1  out_state used key[0] (final beat of block)
err  output  1  sticky; set on key write with idx > NR; cleared only by rst

Behaviour:
- Reset (async, rst=1): all key entries = 0; rptr = NR; out_valid = 0; out_state = 0; out_round = 0; out_last = 0; err = 0; in_ready = 1 once rst deasserts.
- Handshake: in_ready = !out_valid || out_ready (one-stage pipeline register). An input is accepted when in_valid && in_ready. An output is consumed when out_valid && out_ready.
- On accept: out_state <= in_state ^ key[rptr]; out_round <= rptr; out_last <= (rptr == 0); out_valid <= 1. Latency is 1 cycle from accept to out_valid.
- rptr decrements on each accept. After an accept at rptr == 0, rptr wraps to NR.
- Output held stable while out_valid && !out_ready (no data change, no drop).
- out_valid falls the cycle after consumption, unless a new accept happens in the same cycle; in that case it stays 1 with the new data (full throughput, 1 beat/cycle).
- start: rptr <= NR. If start and accept occur in the same cycle, the accepted input uses key[NR] and rptr becomes NR-1. start never affects the output register.
- Key write: key[key_wr_idx] <= key_wr_data when idx <= NR. If idx > NR, the write is ignored and err <= 1.
- Write and read of the same entry in the same cycle: the read returns the old key (write takes effect next cycle).
- Writes are permitted mid-block. Software is responsible for coherency.
- Reset mid-block: the pending output is discarded; the key bank and rptr are reinitialised as above.

Decomposition:
- Shared package aes_pkg: AES_BLOCK_W = 128; NR_128/192/256 = 10/12/14; round-index typedef.
- One sub-module: round_key_bank. It contains the NR+1 x BLOCK_W register array, the write port with range check/err flag, and an async read port.
- The top level holds the round pointer, the handshake, and the XOR/output register.

Test Plan:
- Known vector: load key[10] = D4BF5D30E0B452AEB84111F11E2798E5; pulse start; in_state = 046681E5E0CB199A48F8D37A2806264C with out_ready=1 -> next cycle out_state = d0d9dcd5007f4b34f0b9c28b3621bea9, out_round = 10, out_last = 0.
- Full block: key[i] = {16{8'(i)}}, i = 0..10; stream 11 states of all-zero, back-to-back -> out_state = key[10]..key[0] on 11 consecutive cycles; out_last = 1 only on the 11th beat; 12th input uses key[10] (wrap).
- Backpressure: out_ready = 0 for 3 cycles with in_valid held -> in_ready = 0 after the first accept; out_state stable; no beats lost; rptr decremented exactly once per accepted beat.
- start mid-block: after 4 accepts (rptr = 6), pulse start together with an accept -> that beat reports out_round = 10, the following beat reports out_round = 9.
- Error and hazard: write idx = 11 (NR = 10) -> err = 1 and the bank is unchanged. Write key[10] in the same cycle as an accept at rptr = 10 -> out_state uses the old key[10].
- Async reset: assert rst mid-stream, between clock edges -> out_valid = 0 immediately, err = 0, and the first post-reset beat XORs with 0 (out_state = in_state) and reports out_round = NR.
